// File: rtl/delta_decoder_pkg.sv
// Shared definitions for the delta-modulation decoder: spike code values
// and the controller state encoding.
package delta_pkg;

  // Two-bit spike codes, laid out as {dir,event}
  localparam logic [1:0] SPK_NONE = 2'b00;
  localparam logic [1:0] SPK_UP   = 2'b01;
  localparam logic [1:0] SPK_DOWN = 2'b11;
  localparam logic [1:0] SPK_BAD  = 2'b10;

  // Controller states: waiting for the first init_load, or decoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/delta_decoder_if.sv
// Spike-code input and sample output streams of the decoder, each with a
// valid/ready handshake. The decoder takes the slave side.
interface delta_decoder_if #(
  parameter int WIDTH = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       spike;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Producer of codes and consumer of samples
  modport master (
    output in_valid,
    output spike,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // The decoder itself
  modport slave (
    input  in_valid,
    input  spike,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/delta_decoder_sat_acc.sv
// Combinational saturating step of the accumulator. The step is
// threshold+1 and is formed one bit wider than the sample so that the
// largest threshold still yields a full 2^WIDTH step.
module delta_sat_acc #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] threshold,
  input  logic             dir_down,
  output logic [WIDTH-1:0] result,
  output logic             clip
);

  logic [WIDTH:0] step;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Add or subtract the step, clamping to the sample range and flagging a clip
  always_comb begin
    step   = {1'b0, threshold} + {{WIDTH{1'b0}}, 1'b1};
    sum    = {1'b0, acc} + step;
    diff   = {1'b0, acc} - step;
    result = acc;
    clip   = 1'b0;
    if (dir_down) begin
      if (step > {1'b0, acc}) begin
        result = '0;
        clip   = 1'b1;
      end else begin
        result = diff[WIDTH-1:0];
      end
    end else begin
      if (sum[WIDTH]) begin
        result = '1;
        clip   = 1'b1;
      end else begin
        result = sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/delta_decoder.sv
// Delta-modulation decoder: each accepted spike code moves a saturating
// accumulator by one step, and the new value is presented one cycle later
// on a registered valid/ready output. Also keeps UP/DOWN statistics and
// sticky saturation and error flags.
module delta_decoder
  import delta_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_load,
  input  logic [WIDTH-1:0] init_value,
  input  logic [WIDTH-1:0] threshold,
  input  logic             off_enable,
  delta_decoder_if.slave   bus,
  output logic             sat_hit,
  output logic             err,
  output logic [CNT_W-1:0] up_cnt,
  output logic [CNT_W-1:0] down_cnt
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] step_result;
  logic             step_clip;
  logic [WIDTH-1:0] acc_next;
  logic             accept;
  logic             code_up;
  logic             code_down;
  logic             code_bad;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign accept        = bus.in_valid & bus.in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: init_load enters or re-enters RUN, nothing ever leaves it
  always_comb begin
    state_next = state;
    if (init_load) begin
      state_next = ST_RUN;
    end
  end

  // Input handshake: only in RUN, never during a reload, and only when the output slot is free
  always_comb begin
    bus.in_ready = 1'b0;
    if (state == ST_RUN && !init_load && (!out_valid_q || bus.out_ready)) begin
      bus.in_ready = 1'b1;
    end
  end

  // Classify the incoming code against the current off_enable setting
  always_comb begin
    code_up   = (bus.spike == SPK_UP);
    code_down = (bus.spike == SPK_DOWN) && off_enable;
    code_bad  = (bus.spike == SPK_BAD) || ((bus.spike == SPK_DOWN) && !off_enable);
  end

  delta_sat_acc #(
    .WIDTH(WIDTH)
  ) u_sat_acc (
    .acc      (acc),
    .threshold(threshold),
    .dir_down (code_down),
    .result   (step_result),
    .clip     (step_clip)
  );

  // Only legal UP/DOWN codes move the accumulator; NONE and bad codes leave it alone
  always_comb begin
    acc_next = acc;
    if (code_up || code_down) begin
      acc_next = step_result;
    end
  end

  // Accumulator, output register and sticky flags; a reload drops any pending sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_hit     <= 1'b0;
      err         <= 1'b0;
    end else if (init_load) begin
      acc         <= init_value;
      out_valid_q <= 1'b0;
      sat_hit     <= 1'b0;
      err         <= 1'b0;
    end else if (accept) begin
      acc         <= acc_next;
      out_data_q  <= acc_next;
      out_valid_q <= 1'b1;
      if ((code_up || code_down) && step_clip) begin
        sat_hit <= 1'b1;
      end
      if (code_bad) begin
        err <= 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Spike statistics, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_cnt   <= '0;
      down_cnt <= '0;
    end else if (init_load) begin
      up_cnt   <= '0;
      down_cnt <= '0;
    end else if (accept) begin
      if (code_up && (up_cnt != '1)) begin
        up_cnt <= up_cnt + 1'b1;
      end
      if (code_down && (down_cnt != '1)) begin
        down_cnt <= down_cnt + 1'b1;
      end
    end
  end

endmodule
